data_concat: RTL and testbench

DATA_CONCAT -- requirements
Module: data_concat

---
 rtl/data_concat.sv | 36 +++
 tb/tb_data_concat.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_concat.sv
// Packs four 18-bit words into nine registered bytes (72 bits, pure bit permutation).
// Define DATA_CONCAT_LITTLE_ENDIAN_EN for LSB-first byte order; MSB-first otherwise.
module data_concat (
  input  logic        clk,
  input  logic        srst_n,
  input  logic [17:0] x [4],
  output logic [7:0]  y [9]
);

  logic [71:0] w;
  logic [7:0]  y_nxt [9];

  // x[0] is the most significant word of the combined bus.
  assign w = {x[0], x[1], x[2], x[3]};

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      y_nxt[i] = 8'h00;
`ifdef DATA_CONCAT_LITTLE_ENDIAN_EN
      y_nxt[i] = w[8*i +: 8];
`else
      y_nxt[i] = w[64-8*i +: 8];
`endif
    end
  end

  // The output register is the only state in the block.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < 9; i++) y[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 9; i++) y[i] <= y_nxt[i];
    end
  end

endmodule

// File: tb/tb_data_concat.sv
// Randomized scoreboard bench for data_concat: reset, directed vectors, walking one, random traffic.
module tb_data_concat;

  logic        clk;
  logic        srst_n;
  logic [17:0] x [4];
  logic [7:0]  y [9];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [71:0] exp_q[$];
  int          cap_q[$];
  logic [71:0] prev_exp;
  bit          done = 0;

  data_concat dut (
    .clk    (clk),
    .srst_n (srst_n),
    .x      (x),
    .y      (y)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference: treat the words as one 72-bit number, then slice bytes by arithmetic shift.
  function automatic logic [71:0] model(input logic [17:0] a, input logic [17:0] b,
                                        input logic [17:0] c, input logic [17:0] d);
    logic [71:0] wv;
    logic [71:0] r;
    logic [7:0]  bt;
    wv = (72'(a) << 54) | (72'(b) << 36) | (72'(c) << 18) | 72'(d);
    r  = '0;
    for (int i = 0; i < 9; i++) begin
`ifdef DATA_CONCAT_LITTLE_ENDIAN_EN
      bt = 8'((wv >> (8*i)) & 72'hff);
`else
      bt = 8'((wv >> (64 - 8*i)) & 72'hff);
`endif
      r = r | (72'(bt) << (64 - 8*i));
    end
    return r;
  endfunction

  function automatic logic [71:0] y_packed();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[71-8*i -: 8] = y[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %018h expected %018h at %0t", name, act, req, $time);
  endtask

  // driver tasks
  task automatic drive(input logic [17:0] a, input logic [17:0] b,
                       input logic [17:0] c, input logic [17:0] d,
                       input logic [71:0] exp_val);
    x[0] = a; x[1] = b; x[2] = c; x[3] = d;
    exp_q.push_back(exp_val);
    cap_q.push_back(cyc + 1);
    #1;
    check("hold_until_edge", y_packed(), prev_exp);
    prev_exp = exp_val;
  endtask

  task automatic drive_model(input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] c, input logic [17:0] d);
    drive(a, b, c, d, model(a, b, c, d));
  endtask

  // monitor: pops expectations whose capture edge has passed
  always @(negedge clk) begin
    if (srst_n === 1'b1 && exp_q.size() > 0 && cap_q[0] <= cyc) begin
      check("y_scoreboard", y_packed(), exp_q.pop_front());
      void'(cap_q.pop_front());
    end
  end

  initial begin
    logic [71:0] one;
    logic [71:0] req21;
    srst_n = 1'b0;
    x[0] = 18'h2560a; x[1] = 18'h00000; x[2] = 18'h0ffff; x[3] = 18'h00000;
    prev_exp = '0;
    #1  check("reset_before_edge", y_packed(), 72'h0);
    #11 check("reset_after_edge1", y_packed(), 72'h0);
    #20 check("reset_after_edge2", y_packed(), 72'h0);
    #3  srst_n = 1'b1;  // t=35, between edges
`ifdef DATA_CONCAT_LITTLE_ENDIAN_EN
    drive_model(18'h2560a, 18'h00000, 18'h0ffff, 18'h00000);
    req21 = 72'h7310ca490fb2998295;
`else
    drive(18'h2560a, 18'h00000, 18'h0ffff, 18'h00000, 72'h958280_0003fffc_0000);
    req21 = 72'h958299b20f49ca1073;
`endif
    @(posedge clk); #2;
    drive(18'h2560a, 18'h19b20, 18'h3d272, 18'h21073, req21);

    // walking one across all 72 input bits
    for (int k = 0; k < 72; k++) begin
      @(posedge clk); #2;
      one = 72'h1 << k;
      drive_model(one[71:54], one[53:36], one[35:18], one[17:0]);
    end

    // random traffic with an asynchronous reset dropped mid-stream
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #2;
      if (k == 60) begin
        #3 srst_n = 1'b0;
        #1 check("async_reset_immediate", y_packed(), 72'h0);
        exp_q.delete();
        cap_q.delete();
        prev_exp = '0;
        @(negedge clk); #1;
        check("reset_held_at_negedge", y_packed(), 72'h0);
        #3 srst_n = 1'b1;
      end
      drive_model(18'($urandom_range(0, 18'h3ffff)), 18'($urandom_range(0, 18'h3ffff)),
                  18'($urandom_range(0, 18'h3ffff)), 18'($urandom_range(0, 18'h3ffff)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    // final report
    $display("%0d/%0d checks passed", passed, checks);
    done = 1;
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", passed, checks);
      $fatal(1);
    end
  end

endmodule
